// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Shared types and arithmetic helpers for the FIR MAC engine.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } fir_state_t;

    // Wide signed working type for rounding and saturation. It is large
    // enough for any sensible accumulator, so the rounding add never wraps.
    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic  sat;
        wide_t val;
    } sat_res_t;

    // Tap count of zero means one tap; anything above the line depth is capped.
    function automatic int unsigned clamp_taps(input int unsigned tc, input int unsigned max_taps);
        if (tc == 0)
            return 1;
        else if (tc > max_taps)
            return max_taps;
        else
            return tc;
    endfunction

    // Round-half-up arithmetic right shift; a shift of zero passes through.
    function automatic wide_t round_shift(input wide_t v, input int unsigned sh);
        wide_t one;
        one = {{(WIDE_W-1){1'b0}}, 1'b1};
        if (sh == 0)
            return v;
        return (v + (one <<< (sh - 1))) >>> sh;
    endfunction

    // Clip to the signed range of a w-bit result and flag when clipped.
    function automatic sat_res_t saturate(input wide_t v, input int unsigned w);
        sat_res_t res;
        wide_t    one;
        wide_t    hi;
        wide_t    lo;
        one     = {{(WIDE_W-1){1'b0}}, 1'b1};
        hi      = (one <<< (w - 1)) - one;
        lo      = -(one <<< (w - 1));
        res.sat = 1'b0;
        res.val = v;
        if (v > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (v < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_engine_if
//  Brief    : Coefficient, sample and result streams of the FIR MAC engine.
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_engine_if #(
    parameter int MAX_TAPS = 16,
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 32,
    parameter int COEFF_W  = 32,
    parameter int ACC_W    = DATA_W + COEFF_W + $clog2(MAX_TAPS)
);
    localparam int CNT_W = $clog2(MAX_TAPS + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SH_W  = $clog2(ACC_W);

    logic [CNT_W-1:0]   tap_count;
    logic [SH_W-1:0]    out_shift;
    logic               coeff_start;
    logic               coeff_valid;
    logic [COEFF_W-1:0] coeff_data;
    logic               coeff_ready;
    logic               coeff_done;
    logic               s_valid;
    logic [DATA_W-1:0]  s_data;
    logic [CH_W-1:0]    s_ch;
    logic               s_ready;
    logic               m_valid;
    logic               m_ready;
    logic [DATA_W-1:0]  m_data;
    logic [CH_W-1:0]    m_ch;
    logic               m_sat;
    logic               m_primed;
    logic               busy;

    // Engine side
    modport slave (
        input  tap_count, out_shift, coeff_start, coeff_valid, coeff_data,
        input  s_valid, s_data, s_ch, m_ready,
        output coeff_ready, coeff_done, s_ready, m_valid, m_data, m_ch,
        output m_sat, m_primed, busy
    );

    // Control / consumer side
    modport master (
        output tap_count, out_shift, coeff_start, coeff_valid, coeff_data,
        output s_valid, s_data, s_ch, m_ready,
        input  coeff_ready, coeff_done, s_ready, m_valid, m_data, m_ch,
        input  m_sat, m_primed, busy
    );

endinterface
`default_nettype wire

// File: rtl/fir_channel_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_channel_buffer
//  Brief    : Per-channel circular delay line with write pointer, fill count
//             and a combinational "k samples ago" read port.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_channel_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_flush,
    input  wire logic                     i_wr_en,
    input  wire logic signed [DATA_W-1:0] i_wr_data,
    input  wire logic                     i_advance,
    input  wire logic [CNT_W-1:0]         i_taps,
    input  wire logic [IDX_W-1:0]         i_rd_k,
    output logic signed [DATA_W-1:0]      o_rd_data,
    output logic                          o_primed_nxt
);
    logic signed [DATA_W-1:0] r_line [DEPTH];
    logic [IDX_W-1:0]         r_wptr;
    logic [CNT_W-1:0]         r_fill;

    logic [CNT_W-1:0] w_wptr_ext;
    logic [CNT_W-1:0] w_k_ext;
    logic [CNT_W-1:0] w_rd_idx;
    logic [CNT_W-1:0] w_wptr_inc;

    assign w_wptr_ext = CNT_W'(r_wptr);
    assign w_k_ext    = CNT_W'(i_rd_k);
    // (wptr - k) mod taps, with both operands already below taps
    assign w_rd_idx   = (w_wptr_ext >= w_k_ext) ? (w_wptr_ext - w_k_ext)
                                                : (w_wptr_ext + i_taps - w_k_ext);
    assign o_rd_data  = r_line[w_rd_idx[IDX_W-1:0]];
    assign w_wptr_inc = w_wptr_ext + CNT_W'(1);
    // Primed once the sample being retired brings the count up to taps
    assign o_primed_nxt = (r_fill >= (i_taps - CNT_W'(1)));

    // Delay line storage, pointer advance and saturating fill counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
            r_wptr <= '0;
            r_fill <= '0;
        end else begin
            if (i_wr_en)
                r_line[r_wptr] <= i_wr_data;
            if (i_advance) begin
                r_wptr <= (w_wptr_inc >= i_taps) ? '0 : w_wptr_inc[IDX_W-1:0];
                if (r_fill < i_taps)
                    r_fill <= r_fill + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_engine
//  Brief    : Multi-channel FIR filter built on one time-shared MAC, with
//             coefficient loading, rounding shift and output saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_engine #(
    parameter int MAX_TAPS = 16,
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 32,
    parameter int COEFF_W  = 32,
    parameter int ACC_W    = DATA_W + COEFF_W + $clog2(MAX_TAPS)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fir_mac_engine_if.slave     bus
);
    import fir_pkg::*;

    localparam int CNT_W = $clog2(MAX_TAPS + 1);
    localparam int IDX_W = $clog2(MAX_TAPS);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SH_W  = $clog2(ACC_W);

    fir_state_t r_state;
    fir_state_t w_state_nxt;

    logic [CNT_W-1:0]          r_taps;
    logic [IDX_W-1:0]          r_cptr;
    logic signed [COEFF_W-1:0] r_coeff [MAX_TAPS];
    logic                      r_coeff_done;
    logic [CH_W-1:0]           r_ch;
    logic [SH_W-1:0]           r_shift;
    logic signed [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]          r_k;
    logic [DATA_W-1:0]         r_m_data;
    logic [CH_W-1:0]           r_m_ch;
    logic                      r_m_sat;
    logic                      r_m_primed;

    logic                      w_start;
    logic                      w_accept;
    logic                      w_ch_ok;
    logic                      w_coeff_wr;
    logic                      w_coeff_last;
    logic                      w_mac_last;
    logic signed [DATA_W-1:0]  w_rd_data    [NUM_CH];
    logic                      w_primed_nxt [NUM_CH];
    logic signed [ACC_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    wide_t                     w_acc_wide;
    wide_t                     w_rounded;
    sat_res_t                  w_sat_res;

    assign w_ch_ok = (int'(bus.s_ch) < NUM_CH);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and control strobes. A coeff_start that coincides with an
    // offered sample wins; that sample's handshake completes but it is discarded.
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_coeff_wr   = 1'b0;
        w_coeff_last = 1'b0;
        w_mac_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.coeff_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else if (bus.s_valid && r_coeff_done) begin
                    w_accept = 1'b1;
                    if (w_ch_ok)
                        w_state_nxt = ST_MAC;
                end
            end
            ST_LOAD: begin
                if (bus.coeff_valid) begin
                    w_coeff_wr = 1'b1;
                    if (CNT_W'(r_cptr) == (r_taps - CNT_W'(1))) begin
                        w_coeff_last = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            ST_MAC: begin
                if (CNT_W'(r_k) == (r_taps - CNT_W'(1))) begin
                    w_mac_last  = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.m_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            fir_channel_buffer #(
                .DEPTH  (MAX_TAPS),
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W),
                .IDX_W  (IDX_W)
            ) u_buf (
                .clk          (clk),
                .rst          (rst),
                .i_flush      (w_start),
                .i_wr_en      (w_accept && w_ch_ok && (bus.s_ch == CH_W'(c))),
                .i_wr_data    (bus.s_data),
                .i_advance    (w_mac_last && (r_ch == CH_W'(c))),
                .i_taps       (r_taps),
                .i_rd_k       (r_k),
                .o_rd_data    (w_rd_data[c]),
                .o_primed_nxt (w_primed_nxt[c])
            );
        end
    endgenerate

    // One tap of the dot product, then round and clip the completed sum
    assign w_prod     = ACC_W'(r_coeff[r_k]) * ACC_W'(w_rd_data[r_ch]);
    assign w_acc_next = r_acc + w_prod;
    assign w_acc_wide = WIDE_W'(w_acc_next);
    assign w_rounded  = round_shift(w_acc_wide, 32'(r_shift));
    assign w_sat_res  = saturate(w_rounded, DATA_W);

    // Coefficient store, sample context, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taps       <= CNT_W'(1);
            r_cptr       <= '0;
            for (int i = 0; i < MAX_TAPS; i++) r_coeff[i] <= '0;
            r_coeff_done <= 1'b0;
            r_ch         <= '0;
            r_shift      <= '0;
            r_acc        <= '0;
            r_k          <= '0;
            r_m_data     <= '0;
            r_m_ch       <= '0;
            r_m_sat      <= 1'b0;
            r_m_primed   <= 1'b0;
        end else begin
            if (w_start) begin
                r_taps       <= CNT_W'(clamp_taps(32'(bus.tap_count), MAX_TAPS));
                r_cptr       <= '0;
                r_coeff_done <= 1'b0;
            end
            if (w_coeff_wr) begin
                r_coeff[r_cptr] <= bus.coeff_data;
                r_cptr          <= r_cptr + IDX_W'(1);
                if (w_coeff_last)
                    r_coeff_done <= 1'b1;
            end
            if (w_accept) begin
                r_ch    <= bus.s_ch;
                r_shift <= bus.out_shift;
                r_acc   <= '0;
                r_k     <= '0;
            end
            if (r_state == ST_MAC) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + IDX_W'(1);
            end
            if (w_mac_last) begin
                r_m_data   <= w_sat_res.val[DATA_W-1:0];
                r_m_ch     <= r_ch;
                r_m_sat    <= w_sat_res.sat;
                r_m_primed <= w_primed_nxt[r_ch];
            end
        end
    end

    assign bus.coeff_ready = (r_state == ST_LOAD);
    assign bus.coeff_done  = r_coeff_done;
    assign bus.s_ready     = (r_state == ST_IDLE) && r_coeff_done;
    assign bus.m_valid     = (r_state == ST_OUT);
    assign bus.m_data      = r_m_data;
    assign bus.m_ch        = r_m_ch;
    assign bus.m_sat       = r_m_sat;
    assign bus.m_primed    = r_m_primed;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_engine
//  Brief    : Self-checking bench for fir_mac_engine (16-bit data, 3 channels)
//             against a history-queue dot-product reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_engine;

    localparam int MT    = 16;
    localparam int NCH   = 3;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int AW    = DW + CW + $clog2(MT);
    localparam int CNT_W = $clog2(MT + 1);
    localparam int CH_W  = $clog2(NCH);
    localparam int SH_W  = $clog2(AW);
    localparam longint DMAX = 32767;
    localparam longint DMIN = -32768;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fir_mac_engine_if #(.MAX_TAPS(MT), .NUM_CH(NCH), .DATA_W(DW), .COEFF_W(CW)) bus ();

    fir_mac_engine #(
        .MAX_TAPS (MT),
        .NUM_CH   (NCH),
        .DATA_W   (DW),
        .COEFF_W  (CW),
        .ACC_W    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: coefficients and per-channel newest-first sample history
    longint mdl_coef [MT];
    int     mdl_taps;
    longint mdl_hist [NCH][MT];
    int     mdl_cnt  [NCH];

    longint cv [MT];
    longint t4_in  [4] = '{6, -6, 5, 123};
    int     t4_sh  [4] = '{2, 2, 2, 0};
    longint t4_exp [4] = '{2, -1, 1, 123};
    longint t1_exp [5] = '{1, 2, 3, 4, 0};
    int     t1_pri [5] = '{0, 0, 0, 1, 1};

    longint o_d;
    bit     o_s;
    bit     o_p;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_flush();
        for (int c = 0; c < NCH; c++) begin
            mdl_cnt[c] = 0;
            for (int k = 0; k < MT; k++) mdl_hist[c][k] = 0;
        end
    endfunction

    function automatic void mdl_push(input int ch, input longint x);
        for (int k = MT - 1; k > 0; k--) mdl_hist[ch][k] = mdl_hist[ch][k-1];
        mdl_hist[ch][0] = x;
        mdl_cnt[ch]++;
    endfunction

    function automatic void mdl_result(input int ch, input int sh,
                                       output longint d, output bit sat, output bit pri);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < mdl_taps; k++) acc += mdl_coef[k] * mdl_hist[ch][k];
        r   = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
        sat = 1'b0;
        d   = r;
        if (r > DMAX) begin d = DMAX; sat = 1'b1; end
        if (r < DMIN) begin d = DMIN; sat = 1'b1; end
        pri = (mdl_cnt[ch] >= mdl_taps);
    endfunction

    task automatic load_coeffs(input int tc, input longint c_in[MT]);
        int  n_acc;
        int  n_exp;
        int  cyc;
        bit  hs;
        n_acc = 0;
        cyc   = 0;
        n_exp = (tc == 0) ? 1 : ((tc > MT) ? MT : tc);
        bus.tap_count   = CNT_W'(tc);
        bus.coeff_start = 1'b1;
        tick();
        bus.coeff_start = 1'b0;
        chk("load_coeff_ready", bus.coeff_ready, 1);
        chk("load_done_cleared", bus.coeff_done, 0);
        while (!bus.coeff_done && cyc < 200) begin
            bus.coeff_valid = ($urandom_range(0, 3) != 0);
            bus.coeff_data  = CW'(c_in[n_acc % MT]);
            hs = bus.coeff_valid && bus.coeff_ready;
            tick();
            if (hs) n_acc++;
            cyc++;
        end
        chk("load_done", bus.coeff_done, 1);
        // Keep offering words: none may be taken outside LOAD
        bus.coeff_valid = 1'b1;
        repeat (3) begin
            hs = bus.coeff_ready;
            tick();
            if (hs) n_acc++;
        end
        bus.coeff_valid = 1'b0;
        chk("coeff_accepted", n_acc, n_exp);
        mdl_taps = n_exp;
        for (int k = 0; k < MT; k++) mdl_coef[k] = (k < n_exp) ? c_in[k] : 0;
        mdl_flush();
    endtask

    task automatic send_sample(input int ch, input longint x, input int sh, input int hold,
                               input bit poke, output longint d_obs, output bit s_obs,
                               output bit p_obs);
        int     cyc;
        int     lat;
        longint e_d;
        bit     e_s;
        bit     e_p;
        d_obs = 0; s_obs = 0; p_obs = 0;
        bus.s_ch      = CH_W'(ch);
        bus.s_data    = DW'(x);
        bus.out_shift = SH_W'(sh);
        bus.s_valid   = 1'b1;
        bus.m_ready   = (hold == 0);
        cyc = 0;
        while (!bus.s_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!bus.s_ready) begin
            chk("s_ready_wait", bus.s_ready, 1);
            bus.s_valid = 1'b0;
            return;
        end
        tick();
        bus.s_valid = 1'b0;
        if (ch >= NCH) begin
            chk("drop_busy", bus.busy, 0);
            repeat (2) begin
                tick();
                chk("drop_no_valid", bus.m_valid, 0);
            end
            return;
        end
        mdl_push(ch, x);
        mdl_result(ch, sh, e_d, e_s, e_p);
        lat = 1;
        if (poke) begin
            bus.coeff_start = 1'b1;
            bus.tap_count   = CNT_W'(1);
            tick();
            lat++;
            bus.coeff_start = 1'b0;
            chk("poke_coeff_ready", bus.coeff_ready, 0);
        end
        while (!bus.m_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, mdl_taps + 1);
        d_obs = longint'($signed(bus.m_data));
        s_obs = bus.m_sat;
        p_obs = bus.m_primed;
        chk("m_data", d_obs, e_d);
        chk("m_ch", bus.m_ch, ch);
        chk("m_sat", bus.m_sat, e_s);
        chk("m_primed", bus.m_primed, e_p);
        chk("s_ready_in_out", bus.s_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", bus.m_valid, 1);
            chk("hold_data", longint'($signed(bus.m_data)), e_d);
            chk("hold_ch", bus.m_ch, ch);
            chk("hold_s_ready", bus.s_ready, 0);
        end
        bus.m_ready = 1'b1;
        tick();
        chk("valid_drop", bus.m_valid, 0);
        if (poke) chk("poke_done_kept", bus.coeff_done, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.tap_count   = '0;
        bus.out_shift   = '0;
        bus.coeff_start = 1'b0;
        bus.coeff_valid = 1'b0;
        bus.coeff_data  = '0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_ch        = '0;
        bus.m_ready     = 1'b1;
        mdl_taps        = 1;
        mdl_flush();
        repeat (3) tick();

        // Reset state
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_ch", bus.m_ch, 0);
        chk("rst_m_sat", bus.m_sat, 0);
        chk("rst_m_primed", bus.m_primed, 0);
        chk("rst_coeff_done", bus.coeff_done, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        // Impulse response, 4 taps
        for (int k = 0; k < MT; k++) cv[k] = (k < 4) ? k + 1 : 0;
        load_coeffs(4, cv);
        for (int i = 0; i < 5; i++) begin
            send_sample(0, (i == 0) ? 10'sd1 : 0, 0, 0, 1'b0, o_d, o_s, o_p);
            chk("t1_data", o_d, t1_exp[i]);
            chk("t1_primed", o_p, t1_pri[i]);
        end

        // Interleaved channels share coefficients but not history
        load_coeffs(4, cv);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) send_sample(0, (i == 0) ? 10 : 0, 0, 0, 1'b0, o_d, o_s, o_p);
            send_sample(1, 1, 0, 0, 1'b0, o_d, o_s, o_p);
        end
        send_sample(3, 77, 0, 0, 1'b0, o_d, o_s, o_p);

        // Saturation at both rails
        for (int k = 0; k < MT; k++) cv[k] = 32767;
        load_coeffs(4, cv);
        repeat (4) send_sample(2, 32767, 0, 0, 1'b0, o_d, o_s, o_p);
        chk("t3_pos_sat", o_s, 1);
        load_coeffs(4, cv);
        repeat (4) send_sample(2, -32768, 0, 0, 1'b0, o_d, o_s, o_p);
        chk("t3_neg_data", o_d, DMIN);

        // Rounding shift with a single unit tap
        for (int k = 0; k < MT; k++) cv[k] = (k == 0) ? 1 : 0;
        load_coeffs(1, cv);
        for (int i = 0; i < 4; i++) begin
            send_sample(0, t4_in[i], t4_sh[i], 0, 1'b0, o_d, o_s, o_p);
            chk("t4_round", o_d, t4_exp[i]);
        end

        // Backpressure, tap-count boundaries, coeff_start while busy
        for (int k = 0; k < MT; k++) cv[k] = k - 5;
        load_coeffs(5, cv);
        send_sample(1, 300, 1, 5, 1'b0, o_d, o_s, o_p);
        send_sample(1, -200, 0, 0, 1'b1, o_d, o_s, o_p);
        load_coeffs(0, cv);
        send_sample(0, 9, 0, 0, 1'b0, o_d, o_s, o_p);
        load_coeffs(20, cv);
        repeat (17) send_sample(2, 3, 0, 0, 1'b0, o_d, o_s, o_p);

        // Reset in the middle of a MAC sequence
        load_coeffs(8, cv);
        bus.s_ch = '0; bus.s_data = DW'(5); bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        tick();
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_m_valid", bus.m_valid, 0);
        chk("arst_coeff_done", bus.coeff_done, 0);
        chk("arst_s_ready", bus.s_ready, 0);
        tick();
        rst = 1'b0;
        bus.s_valid = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst_no_accept", bus.busy, 0);
            chk("post_rst_s_ready", bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;
        load_coeffs(3, cv);
        send_sample(0, 11, 0, 0, 1'b0, o_d, o_s, o_p);

        // Randomised traffic
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < MT; k++)
                cv[k] = (r % 2 == 0) ? longint'($urandom_range(0, 200)) - 100
                                     : longint'($signed(16'($urandom)));
            load_coeffs(int'($urandom_range(0, 20)), cv);
            for (int n = 0; n < 20; n++) begin
                send_sample(int'($urandom_range(0, 3)),
                            (r % 2 == 0) ? longint'($urandom_range(0, 2000)) - 1000
                                         : longint'($signed(16'($urandom))),
                            int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                            1'b0, o_d, o_s, o_p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
